i2s_dac_serializer: RTL

- Final output stage of fm_synth_top: takes the mixed stereo DAC word from the voice mixer/volume stage and serialises it as standard I2S: s_clk, word_select and serial_data.
- Raises a one-cycle interrupt_out at each frame boundary so the upstream stage and software can supply the next sample.
- Holds a one-entry buffer with a valid/ready handshake. Repeats the last frame on underrun and flags it.

---
 rtl/i2s_dac_serializer.sv | 105 ++++++++++
 1 files changed

// File: rtl/i2s_dac_serializer.sv
// I2S stereo serializer with a one-entry valid/ready sample buffer and frame-boundary interrupt.
// Latency: an accepted pair goes out in the frame after the next frame load. Backpressure: sample_ready is low while the buffer is full.
module i2s_dac_serializer #(
    parameter int NUM_BITS_DAC = 24,
    parameter int SLOT_BITS    = 32,
    parameter int SCLK_DIV     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_BITS_DAC-1:0] sample_l,
    input  logic [NUM_BITS_DAC-1:0] sample_r,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    input  logic                    underrun_clr,
    output logic                    s_clk,
    output logic                    word_select,
    output logic                    serial_data,
    output logic                    interrupt_out,
    output logic                    underrun
);
    localparam int BC_W  = $clog2(2 * SLOT_BITS);
    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    logic [DIV_W-1:0]        div_cnt;
    logic [BC_W-1:0]         bit_cnt;
    logic                    buf_full;
    logic [NUM_BITS_DAC-1:0] buf_l, buf_r;
    logic [NUM_BITS_DAC-1:0] shadow_l, shadow_r;

    logic                    div_wrap, fall_evt, frame_load, accept;
    logic [BC_W-1:0]         nxt_bit_cnt, pos;
    logic                    nxt_ws, nxt_sd;
    logic [NUM_BITS_DAC-1:0] slot_word, shifted;

    assign sample_ready = ~buf_full;
    assign accept       = sample_valid & ~buf_full;
    assign div_wrap     = (div_cnt == DIV_W'(SCLK_DIV - 1));
    assign fall_evt     = div_wrap & s_clk;
    assign frame_load   = fall_evt & (bit_cnt == BC_W'(2 * SLOT_BITS - 1));

    // Next bit position and the data bit that goes with it, driven at the s_clk fall.
    always_comb begin
        nxt_bit_cnt = (bit_cnt == BC_W'(2 * SLOT_BITS - 1)) ? '0 : bit_cnt + BC_W'(1);
        nxt_ws      = (nxt_bit_cnt >= BC_W'(SLOT_BITS));
        pos         = nxt_ws ? nxt_bit_cnt - BC_W'(SLOT_BITS) : nxt_bit_cnt;
        slot_word   = nxt_ws ? shadow_r : shadow_l;
        shifted     = slot_word << (pos - BC_W'(1));
        nxt_sd      = 1'b0;
        if (pos >= BC_W'(1) && pos <= BC_W'(NUM_BITS_DAC)) begin
            nxt_sd = shifted[NUM_BITS_DAC-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt       <= '0;
            bit_cnt       <= '0;
            s_clk         <= 1'b0;
            word_select   <= 1'b0;
            serial_data   <= 1'b0;
            interrupt_out <= 1'b0;
            underrun      <= 1'b0;
            buf_full      <= 1'b0;
            buf_l         <= '0;
            buf_r         <= '0;
            shadow_l      <= '0;
            shadow_r      <= '0;
        end else begin
            if (div_wrap) begin
                div_cnt <= '0;
                s_clk   <= ~s_clk;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            if (fall_evt) begin
                bit_cnt     <= nxt_bit_cnt;
                word_select <= nxt_ws;
                serial_data <= nxt_sd;
            end

            interrupt_out <= frame_load;

            if (frame_load && buf_full) begin
                shadow_l <= buf_l;
                shadow_r <= buf_r;
            end

            // No bypass: a pair accepted on the load edge waits for the next frame.
            if (accept) begin
                buf_l    <= sample_l;
                buf_r    <= sample_r;
                buf_full <= 1'b1;
            end else if (frame_load) begin
                buf_full <= 1'b0;
            end

            if (frame_load && !buf_full) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
        end
    end
endmodule
